alu_exec_unit: RTL

//   Execution-side consumer of the 4-bit ALU control code from the ALU control decoder.

---
 rtl/alu_exec_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : EX-stage ALU with valid/ready handshake and registered result/flags.
//            Optional iterative shift-add multiplier, enabled by macro MULT_EN.
// Revision : 1.0  initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_cnt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);
    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_NOR = 4'b1100;
`ifdef MULT_EN
    localparam logic [3:0] c_OP_MUL = 4'b1000;
`endif

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_result;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_ill;

    assign in_ready = (r_state == IDLE) & (~out_valid | out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_sum    = a + b;
    assign w_diff   = a - b;

    // Single-cycle operations; MUL is routed to the iterative datapath instead.
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        case (alu_cnt)
            c_OP_AND: w_res = a & b;
            c_OP_OR:  w_res = a | b;
            c_OP_ADD: begin
                w_res = w_sum;
                w_ovf = (a[WIDTH-1] == b[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res = w_diff;
                w_ovf = (a[WIDTH-1] != b[WIDTH-1]) & (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_OP_NOR: w_res = ~(a | b);
`ifdef MULT_EN
            c_OP_MUL: w_res = '0;
`endif
            default:  w_ill = 1'b1;
        endcase
    end

`ifdef MULT_EN
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_prod;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] w_prod_next;

    assign w_is_mul     = (alu_cnt == c_OP_MUL);
    assign w_prod_next  = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_done   = (r_state == MUL_BUSY) && (r_count == CNT_W'(WIDTH - 1));
    assign w_mul_result = w_prod_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_count  <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_prod   <= '0;
            r_count  <= '0;
        end else if (r_state == MUL_BUSY) begin
            r_prod   <= w_prod_next;
            r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_count  <= r_count + 1'b1;
        end
    end
`else
    assign w_is_mul     = 1'b0;
    assign w_mul_done   = 1'b0;
    assign w_mul_result = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_accept && w_is_mul) w_state_next = MUL_BUSY;
            MUL_BUSY: if (w_mul_done) w_state_next = IDLE;
        endcase
    end

    // Output register: a new result replaces the retiring one with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            out_valid <= 1'b1;
            result    <= w_res;
            zero      <= (w_res == '0);
            overflow  <= w_ovf;
            illegal   <= w_ill;
        end else if (w_mul_done) begin
            out_valid <= 1'b1;
            result    <= w_mul_result;
            zero      <= (w_mul_result == '0);
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire
